// File: rtl/mapper_mem_arbiter_if.sv
// mapper_mem_arbiter_if: requester and memory-side bus of the mapper memory arbiter.
interface mapper_mem_arbiter_if;
   logic [2:0]  req;
   logic [26:0] addr0, addr1, addr2;
   logic [2:0]  wr;
   logic [7:0]  wdata0, wdata1, wdata2;
   logic [2:0]  ack;
   logic [7:0]  rdata;
   logic        mem_req;
   logic [26:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic        timeout_err;
   modport slave (
      input  req, addr0, addr1, addr2, wr, wdata0, wdata1, wdata2, mem_ready, mem_rdata,
      output ack, rdata, mem_req, mem_addr, mem_we, mem_wdata, timeout_err
   );
   modport master (
      output req, addr0, addr1, addr2, wr, wdata0, wdata1, wdata2, mem_ready, mem_rdata,
      input  ack, rdata, mem_req, mem_addr, mem_we, mem_wdata, timeout_err
   );
endinterface

// File: rtl/mapper_mem_arbiter.sv
// mapper_mem_arbiter: three-requester arbiter (loader first, slots round-robin) in front of one
// single-outstanding memory port, with a WAIT-state timeout that forces completion.
module mapper_mem_arbiter #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   mapper_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  win_q, win_d, pick;
   logic        last_q, last_d;
   logic [26:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
   logic        terr_q, terr_d;

   // last_q = 1 means slot 1 was granted last, so slot 0 wins a tie
   assign pick = bus.req[2] ? 2'd2 : (bus.req[0] && (!bus.req[1] || last_q)) ? 2'd0 : 2'd1;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE: if (|bus.req) begin
            win_d   = pick;
            last_d  = (pick == 2'd2) ? last_q : pick[0];
            addr_d  = (pick == 2'd2) ? bus.addr2 : (pick == 2'd1) ? bus.addr1 : bus.addr0;
            we_d    = (pick == 2'd2) ? bus.wr[2] : (pick == 2'd1) ? bus.wr[1] : bus.wr[0];
            wdata_d = (pick == 2'd2) ? bus.wdata2 : (pick == 2'd1) ? bus.wdata1 : bus.wdata0;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: if (bus.mem_ready) begin
            rdata_d = we_q ? rdata_q : bus.mem_rdata;
            state_d = DONE;
         end else if (cnt_q + 8'd1 == 8'(TIMEOUT_CYC)) begin
            terr_d  = 1'b1;
            rdata_d = 8'hFF;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         win_q   <= 2'd0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 8'd0;
         rdata_q <= 8'hFF;
         cnt_q   <= 8'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   assign bus.ack         = (state_q == DONE) ? (3'b001 << win_q) : 3'b000;
   assign bus.mem_req     = (state_q == ISSUE);
   assign bus.mem_addr    = addr_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.rdata       = rdata_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: doc/mapper_mem_arbiter.md
MAPPER_MEM_ARBITER -- requirements
Module: mapper_mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 255, max cycles waited for mem_ready before a forced abort.
REQ-002 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req[2:0]  in  3  level request; [0] cartridge slot 0, [1] cartridge slot 1, [2] ROM loader.
REQ-005 SHALL have ports: addr0, addr1, addr2  in  27 each  byte address per requester.
REQ-006 SHALL have ports: wr[2:0]  in  3  1 = write, 0 = read, per requester.
REQ-007 SHALL have ports: wdata0, wdata1, wdata2  in  8 each  write data per requester.
REQ-008 SHALL have ports: ack[2:0]  out  3  one-cycle completion pulse per requester.
REQ-009 SHALL have ports: rdata  out  8  read data, valid in the ack cycle.
REQ-010 SHALL have ports: mem_req  out  1; mem_addr  out  27; mem_we  out  1; mem_wdata  out  8; mem_ready  in  1; mem_rdata  in  8.
REQ-011 SHALL have ports: timeout_err  out  1  sticky abort flag.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-013 IDLE: when any req bit is set, SHALL select a winner, latch its addr/wr/wdata into internal registers, and enter ISSUE on the next cycle.
REQ-014 Priority: req[2] (loader) SHALL always win; between slots 0 and 1, SHALL use round-robin with last_grant pointer; the pointer SHALL be updated only on grant of slot 0 or 1.
REQ-015 ISSUE: SHALL drive mem_req = 1 with the latched addr/we/wdata for exactly one cycle, then enter WAIT.
REQ-016 WAIT: SHALL hold mem_addr, mem_we and mem_wdata stable with mem_req = 0; on mem_ready = 1, SHALL capture mem_rdata into rdata (reads only) and enter DONE.
REQ-017 DONE: SHALL assert ack[winner] for exactly one cycle, then return to IDLE; minimum latency req-to-ack = 4 cycles when mem_ready arrives the cycle after ISSUE.
REQ-018 SHALL hold rdata unchanged on write transactions and outside the ack cycle.
REQ-019 SHALL sample a requester's later changes to addr/wr/wdata only at grant; changes mid-transaction SHALL be ignored.
REQ-020 Requester deasserting req before ack: the transaction SHALL still complete and ack SHALL still pulse.
REQ-021 A requester still holding req after its ack SHALL be treated as a new request in IDLE; back-to-back slot requests SHALL alternate 0,1,0,1.
REQ-022 mem_ready while in IDLE, ISSUE or DONE SHALL be ignored.
REQ-023 WAIT counter: 8-bit, cleared on ISSUE; when it reaches TIMEOUT_CYC without mem_ready, SHALL set timeout_err, drive rdata = 8'hFF, and enter DONE (ack still pulses).
REQ-024 timeout_err SHALL stay set until reset.
REQ-025 At most one ack bit SHALL be set in any cycle; ack SHALL never be set outside DONE.

Reset
REQ-026 On reset: state = IDLE; ack = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rdata = 8'hFF; timeout_err = 0; last_grant = slot 1 (so slot 0 wins first); counter = 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it without an ack; the requester SHALL re-request.

Verification
REQ-028 Slot-0 read addr0 = 27'h0004000, mem_ready one cycle after mem_req with mem_rdata = 8'hA5 -> mem_addr = 0004000, mem_we = 0, ack[0] pulses 4 cycles after req, rdata = A5.
REQ-029 req[0] and req[1] both held continuously -> grant order is 0,1,0,1; no ack gaps beyond one IDLE cycle.
REQ-030 req = 3'b111 simultaneously -> loader is served first, then slot 0, then slot 1.
REQ-031 Loader write addr2 = 27'h0010000, wdata2 = 8'h3C -> mem_we = 1, mem_wdata = 3C, ack[2] pulses, rdata unchanged.
REQ-032 mem_ready never asserted -> after 255 WAIT cycles, timeout_err = 1, ack pulses with rdata = FF, and the next request proceeds normally.
REQ-033 Reset asserted in WAIT -> no ack, all outputs at reset values the next cycle, and a new request is served normally.
